ftdi_tx_arbiter: RTL

Packet-level arbiter that shares the FTDI FIFO transmit path between two on-chip byte-stream requesters: channel 0 carries command responses and channel 1 carries the measurement stream. It grants whole packets round-robin and moves bytes into a one-entry output register. It feeds the FTDI output engine's transmit side over a valid/ready handshake. It also enforces a maximum packet length and a per-packet stall timeout, so one requester cannot hold the USB link indefinitely.

---
 rtl/ftdi_tx_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ftdi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the FTDI transmit path between two byte streams.
// Optional header framing is enabled by defining FTDI_ARB_HDR_EN.
module ftdi_tx_arbiter #(
  parameter int pDataWidth = 8,
  parameter int pMaxData   = 64,
  parameter int pTimeout   = 255
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [1:0]            iReqValid,
  input  logic [1:0]            iReqLast,
  input  logic [pDataWidth-1:0] iReqData0,
  input  logic [pDataWidth-1:0] iReqData1,
  output logic [1:0]            oReqReady,
  output logic [pDataWidth-1:0] oTxData,
  output logic                  oTxValid,
  input  logic                  iTxReady,
  output logic [1:0]            oGrant,
  output logic                  oBusy,
  output logic [7:0]            oErrCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef FTDI_ARB_HDR_EN
    HDR  = 2'd1,
`endif
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [7:0] MaxCnt     = 8'(pMaxData);
  localparam logic [7:0] TimeoutCnt = 8'(pTimeout);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [pDataWidth-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            stall_cnt_q, stall_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  last_q, last_d;

  logic                  ch;
  logic                  out_free;
  logic                  req_v;
  logic                  req_last;
  logic [pDataWidth-1:0] req_data;
  logic                  accept;
  logic [7:0]            cnt_inc;
  logic [7:0]            stall_inc;

  assign ch        = grant_q[1];
  // The output register can take a byte if empty or being drained this cycle.
  assign out_free  = !tx_valid_q || iTxReady;
  assign req_v     = iReqValid[ch];
  assign req_last  = iReqLast[ch];
  assign req_data  = ch ? iReqData1 : iReqData0;
  assign accept    = (state_q == XFER) && out_free && req_v;
  assign cnt_inc   = byte_cnt_q + 8'd1;
  assign stall_inc = stall_cnt_q + 8'd1;

  assign oReqReady = ((state_q == XFER) && out_free) ? grant_q : 2'b00;
  assign oTxData   = tx_data_q;
  assign oTxValid  = tx_valid_q;
  assign oGrant    = grant_q;
  assign oBusy     = (state_q != IDLE);
  assign oErrCnt   = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q && !iTxReady;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    err_cnt_d   = err_cnt_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (|iReqValid) begin
          if (&iReqValid) grant_d = last_q ? 2'b01 : 2'b10;
          else            grant_d = iReqValid[1] ? 2'b10 : 2'b01;
`ifdef FTDI_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef FTDI_ARB_HDR_EN
      HDR: begin
        if (out_free) begin
          tx_data_d  = pDataWidth'({4'hA, 3'b000, ch});
          tx_valid_d = 1'b1;
          state_d    = XFER;
        end
      end
`endif
      XFER: begin
        if (accept) begin
          tx_data_d   = req_data;
          tx_valid_d  = 1'b1;
          byte_cnt_d  = cnt_inc;
          stall_cnt_d = 8'd0;
          if (req_last) begin
            state_d = DONE;
          end else if (cnt_inc == MaxCnt) begin
            // Truncated: the rest of the requester's stream becomes a new packet.
            state_d   = DONE;
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end else if (!tx_valid_q) begin
          stall_cnt_d = stall_inc;
          if (stall_inc == TimeoutCnt) begin
            state_d   = DONE;
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end
      end
      DONE: begin
        if (out_free) begin
          last_d      = ch;
          grant_d     = 2'b00;
          byte_cnt_d  = 8'd0;
          stall_cnt_d = 8'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      byte_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_cnt_q   <= err_cnt_d;
      last_q      <= last_d;
    end
  end

endmodule
